logic_result_capture: RTL and testbench
=======================================

Name: logic_result_capture

Overview:
- Downstream stage of logic_test: consumes its four WIDTH-bit results (AND/OR/NOT/XOR) and selects one per beat with a 2-bit opcode.
- Buffers selected words in a DEPTH-entry first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Keeps a running count of accepted words, so combinational logic results can be captured and drained at a downstream pace.

Parameters:
- WIDTH, 4, bit width of each logic result and of the stored word
- DEPTH, 4, FIFO entries; power of two, minimum 2
- CW, $clog2(DEPTH)+1, width of occupancy count (localparam, derived)

Ports:
- LRC_i_clk  input  1  clock; all state updates on rising edge
- LRC_i_rst  input  1  synchronous, active-high reset
- LRC_i_and  input  WIDTH  AND result from logic_test
- LRC_i_or  input  WIDTH  OR result
- LRC_i_not  input  WIDTH  NOT result
- LRC_i_xor  input  WIDTH  XOR result
- LRC_i_sel  input  2  opcode: 00 AND, 01 OR, 10 NOT, 11 XOR
- LRC_i_valid  input  1  upstream word valid
- LRC_o_ready  output  1  block can accept a word
- LRC_o_data  output  WIDTH  head-of-FIFO word
- LRC_o_valid  output  1  LRC_o_data valid
- LRC_i_ready  input  1  downstream accepts head word
- LRC_o_count  output  CW  current occupancy, 0..DEPTH
- LRC_o_full  output  1  count == DEPTH
- LRC_o_empty  output  1  count == 0
- LRC_o_total  output  8  accepted-word counter, wraps 255 -> 0

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high, sampled on the LRC_i_clk rising edge.
- Reset state: wr_ptr = 0, rd_ptr = 0, count = 0, total = 0. So LRC_o_valid = 0, LRC_o_empty = 1, LRC_o_full = 0, LRC_o_data = 0.
- While LRC_i_rst = 1, LRC_o_ready = 0.
- Push: push = LRC_i_valid & LRC_o_ready, where LRC_o_ready = !full & !rst (combinational).
  - On push, mem[wr_ptr] <= mux(LRC_i_sel) and wr_ptr advances modulo DEPTH.
  - Selected value is sampled in the push cycle; later input changes do not affect stored data.
- Pop: pop = LRC_o_valid & LRC_i_ready. On pop, rd_ptr advances modulo DEPTH.
- Output path:
  - LRC_o_valid = !empty.
  - LRC_o_data = mem[rd_ptr] when !empty, else 0 (masked, never X).
- Latency: a word pushed into an empty FIFO appears on LRC_o_data/LRC_o_valid the next cycle (1 cycle). No same-cycle bypass.
- Count update:
  - push only: +1
  - pop only: -1
  - push & pop in the same cycle: unchanged, both pointers advance
- Full: LRC_o_ready = 0 even if a pop occurs in the same cycle. No push-through-full; the freed slot is usable the next cycle.
- Empty: no pop possible. LRC_i_ready is ignored.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Occupancy comes from the explicit count register, not pointer compare.
- total: +1 per push, 8-bit wrap (255 + 1 = 0). Pops do not affect it.
- Reset mid-operation: all stored words are discarded. LRC_o_valid is 0 in the cycle after reset is sampled, and any push in the reset cycle is ignored.
- Protocol rule: upstream may deassert LRC_i_valid at any time. The block never drops a word that has been handshaken.

Optional Feature:
- Macro: LRC_PARITY_EN
- When defined:
  - Each entry stores WIDTH+1 bits: the data plus even parity (^word) computed at push.
  - Extra output port LRC_o_parity (1 bit) = stored parity of the head entry; 0 when empty; 0 after reset.
- When undefined: LRC_o_parity does not exist, and entries are WIDTH bits.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then hold inputs idle → LRC_o_valid = 0, LRC_o_empty = 1, LRC_o_ready = 1, LRC_o_count = 0, LRC_o_total = 0, LRC_o_data = 4'b0000.
- Opcode sweep with AND=0000, OR=0001, NOT=1111, XOR=0001 and sel = 00, 01, 10, 11 pushed on consecutive cycles, LRC_i_ready = 0:
  - FIFO holds 0000, 0001, 1111, 0001; LRC_o_full = 1, LRC_o_ready = 0.
  - Then LRC_i_ready = 1 → words pop in that order over 4 cycles; LRC_o_total = 4.
- Full + pop same cycle: from full, assert LRC_i_valid and LRC_i_ready together → the cycle's push is refused, count 4 → 3. Next cycle push is accepted and count returns to 4.
- Streaming: LRC_i_valid = LRC_i_ready = 1 for 20 cycles with XOR input cycling 1000, 0111, 0111, 0110 →
  - count stays at 1 after the first cycle
  - output equals input delayed by 1 cycle
  - pointers wrap ≥4 times
  - LRC_o_total = 20
- Counter wrap: push 256 words → LRC_o_total reads 0; push one more → 1.
- Mid-operation reset: with 3 words queued, assert LRC_i_rst for 1 cycle while LRC_i_valid = 1 → next cycle count = 0, LRC_o_valid = 0, total = 0, and the pushed word is absent. With LRC_PARITY_EN, a pushed 1011 shows LRC_o_parity = 1 at head, and 0 after reset.

Source files
------------

// File: rtl/logic_result_capture.sv
// logic_result_capture: selects one of four logic results per beat and buffers it in a FWFT FIFO.
// Define LRC_PARITY_EN to store even parity per entry and expose it as LRC_o_parity.
module logic_result_capture #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                         LRC_i_clk,
   input  logic                         LRC_i_rst,
   input  logic [WIDTH-1:0]             LRC_i_and,
   input  logic [WIDTH-1:0]             LRC_i_or,
   input  logic [WIDTH-1:0]             LRC_i_not,
   input  logic [WIDTH-1:0]             LRC_i_xor,
   input  logic [1:0]                   LRC_i_sel,
   input  logic                         LRC_i_valid,
   output logic                         LRC_o_ready,
   output logic [WIDTH-1:0]             LRC_o_data,
   output logic                         LRC_o_valid,
   input  logic                         LRC_i_ready,
   output logic [$clog2(DEPTH):0]       LRC_o_count,
   output logic                         LRC_o_full,
   output logic                         LRC_o_empty,
`ifdef LRC_PARITY_EN
   output logic                         LRC_o_parity,
`endif
   output logic [7:0]                   LRC_o_total
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);
`ifdef LRC_PARITY_EN
   localparam int EW = WIDTH + 1;
`else
   localparam int EW = WIDTH;
`endif
   logic [EW-1:0]    r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [7:0]       r_total;
   logic [WIDTH-1:0] w_sel;
   logic [EW-1:0]    w_entry;
   logic [EW-1:0]    w_head;
   logic             w_push;
   logic             w_pop;
   always_comb begin
      w_sel = LRC_i_sel == 2'd0 ? LRC_i_and :
              LRC_i_sel == 2'd1 ? LRC_i_or  :
              LRC_i_sel == 2'd2 ? LRC_i_not : LRC_i_xor;
`ifdef LRC_PARITY_EN
      w_entry = {^w_sel, w_sel};
`else
      w_entry = w_sel;
`endif
   end
   assign LRC_o_full  = r_count == CW'(DEPTH);
   assign LRC_o_empty = r_count == '0;
   assign LRC_o_ready = !LRC_o_full && !LRC_i_rst;
   assign LRC_o_valid = !LRC_o_empty;
   assign w_push      = LRC_i_valid && LRC_o_ready;
   assign w_pop       = LRC_o_valid && LRC_i_ready;
   assign w_head      = r_mem[r_rd_ptr];
   // Head is masked when empty so stale or uninitialised entries never leak out
   assign LRC_o_data  = LRC_o_empty ? '0 : w_head[WIDTH-1:0];
`ifdef LRC_PARITY_EN
   assign LRC_o_parity = LRC_o_empty ? 1'b0 : w_head[WIDTH];
`endif
   assign LRC_o_count = r_count;
   assign LRC_o_total = r_total;
   always_ff @(posedge LRC_i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_entry;
   end
   always_ff @(posedge LRC_i_clk) begin
      if (LRC_i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_total  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_push) r_total <= r_total + 8'd1;
      end
   end
endmodule

// File: tb/tb_logic_result_capture.sv
// tb_logic_result_capture: directed checks of selection, FIFO ordering, full/empty, wrap and reset.
module tb_logic_result_capture;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] i_and, i_or, i_not, i_xor;
   logic [1:0] sel;
   logic       i_valid, i_ready;
   logic       o_ready, o_valid, o_full, o_empty;
   logic [3:0] o_data;
   logic [2:0] o_count;
   logic [7:0] o_total;
`ifdef LRC_PARITY_EN
   logic       o_parity;
`endif
   int total = 0;
   int bad = 0;
   logic [3:0] exp_q [4];
   logic [3:0] pat [4];
   always #5 clk = ~clk;
   logic_result_capture #(.WIDTH(4), .DEPTH(4)) dut (
      .LRC_i_clk(clk), .LRC_i_rst(rst),
      .LRC_i_and(i_and), .LRC_i_or(i_or), .LRC_i_not(i_not), .LRC_i_xor(i_xor),
      .LRC_i_sel(sel), .LRC_i_valid(i_valid), .LRC_o_ready(o_ready),
      .LRC_o_data(o_data), .LRC_o_valid(o_valid), .LRC_i_ready(i_ready),
      .LRC_o_count(o_count), .LRC_o_full(o_full), .LRC_o_empty(o_empty),
`ifdef LRC_PARITY_EN
      .LRC_o_parity(o_parity),
`endif
      .LRC_o_total(o_total)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b1; i_and = '0; i_or = '0; i_not = '0; i_xor = '0; sel = '0;
      i_valid = 1'b0; i_ready = 1'b0;
      step();
      check("ready_in_rst", 32'(o_ready), 0);
      step();
      rst = 1'b0;
      #1;
      check("idle_valid", 32'(o_valid), 0);
      check("idle_empty", 32'(o_empty), 1);
      check("idle_full", 32'(o_full), 0);
      check("idle_ready", 32'(o_ready), 1);
      check("idle_count", 32'(o_count), 0);
      check("idle_total", 32'(o_total), 0);
      check("idle_data", 32'(o_data), 0);
      // opcode sweep into a stalled FIFO
      i_and = 4'b0000; i_or = 4'b0001; i_not = 4'b1111; i_xor = 4'b0001;
      exp_q = '{4'b0000, 4'b0001, 4'b1111, 4'b0001};
      i_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sel = 2'(i);
         step();
      end
      i_valid = 1'b0;
      check("sweep_count", 32'(o_count), 4);
      check("sweep_full", 32'(o_full), 1);
      check("sweep_ready", 32'(o_ready), 0);
      i_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("sweep_pop%0d", i), 32'(o_data), 32'(exp_q[i]));
         step();
      end
      check("sweep_empty", 32'(o_empty), 1);
      check("sweep_total", 32'(o_total), 4);
      // full with simultaneous push attempt and pop
      i_ready = 1'b0; i_valid = 1'b1; sel = 2'd3;
      for (int i = 0; i < 4; i++) begin
         i_xor = 4'(i + 1);
         step();
      end
      check("refill_full", 32'(o_full), 1);
      i_xor = 4'd5; i_ready = 1'b1;
      #1;
      check("full_pop_ready", 32'(o_ready), 0);
      step();
      check("full_pop_count", 32'(o_count), 3);
      i_xor = 4'd6; i_ready = 1'b0;
      #1;
      check("freed_ready", 32'(o_ready), 1);
      step();
      check("freed_count", 32'(o_count), 4);
      i_valid = 1'b0; i_ready = 1'b1;
      exp_q = '{4'd2, 4'd3, 4'd4, 4'd6};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("full_pop_order%0d", i), 32'(o_data), 32'(exp_q[i]));
         step();
      end
      check("full_pop_total", 32'(o_total), 9);
      // streaming pass-through
      pat = '{4'b1000, 4'b0111, 4'b0111, 4'b0110};
      i_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         i_xor = pat[c % 4];
         step();
         check($sformatf("stream_count%0d", c), 32'(o_count), 1);
         check($sformatf("stream_data%0d", c), 32'(o_data), 32'(pat[c % 4]));
      end
      i_valid = 1'b0;
      step();
      check("stream_drained", 32'(o_empty), 1);
      check("stream_total", 32'(o_total), 29);
      // total counter wrap from a fresh reset
      rst = 1'b1;
      step();
      rst = 1'b0; i_valid = 1'b1;
      for (int c = 0; c < 256; c++) begin
         i_xor = 4'(c);
         step();
      end
      check("total_wrap", 32'(o_total), 0);
      step();
      check("total_wrap_plus1", 32'(o_total), 1);
      i_valid = 1'b0;
      step();
      // reset with words queued and a push pending
      i_ready = 1'b0; i_valid = 1'b1; sel = 2'd0;
      for (int i = 0; i < 3; i++) begin
         i_and = 4'(10 + i);
         step();
      end
      check("queued_count", 32'(o_count), 3);
      rst = 1'b1; i_and = 4'hD;
      #1;
      check("rst_ready", 32'(o_ready), 0);
      step();
      rst = 1'b0; i_valid = 1'b0;
      check("rst_count", 32'(o_count), 0);
      check("rst_valid", 32'(o_valid), 0);
      check("rst_total", 32'(o_total), 0);
      check("rst_data", 32'(o_data), 0);
      step();
      check("rst_push_dropped", 32'(o_count), 0);
`ifdef LRC_PARITY_EN
      i_valid = 1'b1; i_and = 4'b1011;
      step();
      i_valid = 1'b0;
      check("par_data", 32'(o_data), 32'hB);
      check("par_bit", 32'(o_parity), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("par_after_rst", 32'(o_parity), 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
